// File: rtl/vga_pkg.sv
// Shared VGA constants for the ball drawing path.
// The same values are used by draw_ball_ctl, so screen geometry and
// sprite size stay consistent across both blocks.
package vga_pkg;
   localparam int unsigned BALL_DIAMETER = 16;
   localparam int unsigned HOR_PIXELS    = 1024;
   localparam int unsigned VER_PIXELS    = 768;
   localparam int unsigned CENTRAL_LINE  = 511;
   localparam int unsigned RGB_W         = 12;
   localparam int unsigned COORD_W       = 11;
   localparam int unsigned POS_W         = 12;
endpackage

// File: rtl/ball_rom.sv
// 16x16 circular sprite mask, purely combinational.
// Ports:
//   row   - sprite row 0..15
//   col   - sprite column 0..15
//   pixel - 1 when (2*col-15)^2 + (2*row-15)^2 <= 256
module ball_rom (
   input  logic [3:0] row,
   input  logic [3:0] col,
   output logic       pixel
);
   logic [3:0] ac;
   logic [3:0] ar;
   logic [8:0] sum;

   always_comb begin
      // |2c-15| is always odd: 2(c-8)+1 for c>=8, 15-2c for c<8
      ac    = col[3] ? {col[2:0], 1'b1} : 4'd15 - {col[2:0], 1'b0};
      ar    = row[3] ? {row[2:0], 1'b1} : 4'd15 - {row[2:0], 1'b0};
      sum   = {1'b0, {4'b0, ac} * {4'b0, ac}} + {1'b0, {4'b0, ar} * {4'b0, ar}};
      pixel = (sum <= 9'd256);
   end
endmodule

// File: rtl/draw_ball.sv
// Overlays a circular ball sprite on a VGA pixel stream.
// All timing signals pass through with a fixed 2-cycle latency; the ball
// position is captured only on the rising edge of vblnk so a frame never
// tears.
// Ports:
//   pclk, rst               - pixel clock, async active-high reset
//   hcount_in, vcount_in    - upstream pixel coordinates
//   hsync_in .. vblnk_in    - upstream sync / blanking
//   rgb_in                  - upstream colour
//   xpos, ypos              - requested ball top-left corner
//   *_out                   - 2-cycle delayed timing and overlaid colour
module draw_ball #(
   parameter int unsigned                  BALL_DIAMETER = 16,
   parameter logic [vga_pkg::RGB_W-1:0]    BALL_COLOR    = 12'hFFF
) (
   input  logic                           pclk,
   input  logic                           rst,
   input  logic [vga_pkg::COORD_W-1:0]    hcount_in,
   input  logic [vga_pkg::COORD_W-1:0]    vcount_in,
   input  logic                           hsync_in,
   input  logic                           vsync_in,
   input  logic                           hblnk_in,
   input  logic                           vblnk_in,
   input  logic [vga_pkg::RGB_W-1:0]      rgb_in,
   input  logic [vga_pkg::POS_W-1:0]      xpos,
   input  logic [vga_pkg::POS_W-1:0]      ypos,
   output logic [vga_pkg::COORD_W-1:0]    hcount_out,
   output logic [vga_pkg::COORD_W-1:0]    vcount_out,
   output logic                           hsync_out,
   output logic                           vsync_out,
   output logic                           hblnk_out,
   output logic                           vblnk_out,
   output logic [vga_pkg::RGB_W-1:0]      rgb_out
);
   import vga_pkg::*;

   localparam logic [POS_W-1:0] DIAM = POS_W'(BALL_DIAMETER);

   // frame-stable position latch
   logic               vblnk_d;
   logic               vblnk_rise;
   logic               pos_valid;
   logic [POS_W-1:0]   bx;
   logic [POS_W-1:0]   by;

   // stage 1 combinational
   logic [POS_W-1:0]   h_ext;
   logic [POS_W-1:0]   v_ext;
   logic [POS_W-1:0]   dx;
   logic [POS_W-1:0]   dy;
   logic               in_box;

   // stage 1 registers
   logic [COORD_W-1:0] hcount1;
   logic [COORD_W-1:0] vcount1;
   logic               hsync1;
   logic               vsync1;
   logic               hblnk1;
   logic               vblnk1;
   logic [RGB_W-1:0]   rgb1;
   logic [3:0]         row1;
   logic [3:0]         col1;
   logic               in_box1;

   logic               mask_px;
   logic               draw;

   assign vblnk_rise = vblnk_in & ~vblnk_d;

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         vblnk_d   <= 1'b0;
         pos_valid <= 1'b0;
         bx        <= '0;
         by        <= '0;
      end else begin
         vblnk_d <= vblnk_in;
         if (vblnk_rise) begin
            bx        <= xpos;
            by        <= ypos;
            pos_valid <= 1'b1;
         end
      end
   end

   // The explicit >= tests reject wrapped differences, so a box hanging
   // off the right/bottom edge never reappears at column or row 0, and a
   // position beyond the 11-bit coordinate range never matches.
   always_comb begin
      h_ext  = {{(POS_W-COORD_W){1'b0}}, hcount_in};
      v_ext  = {{(POS_W-COORD_W){1'b0}}, vcount_in};
      dx     = h_ext - bx;
      dy     = v_ext - by;
      in_box = (h_ext >= bx) && (dx < DIAM) && (v_ext >= by) && (dy < DIAM);
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         hcount1 <= '0;
         vcount1 <= '0;
         hsync1  <= 1'b0;
         vsync1  <= 1'b0;
         hblnk1  <= 1'b0;
         vblnk1  <= 1'b0;
         rgb1    <= '0;
         row1    <= '0;
         col1    <= '0;
         in_box1 <= 1'b0;
      end else begin
         hcount1 <= hcount_in;
         vcount1 <= vcount_in;
         hsync1  <= hsync_in;
         vsync1  <= vsync_in;
         hblnk1  <= hblnk_in;
         vblnk1  <= vblnk_in;
         rgb1    <= rgb_in;
         row1    <= dy[3:0];
         col1    <= dx[3:0];
         in_box1 <= in_box;
      end
   end

   ball_rom u_ball_rom (
      .row   (row1),
      .col   (col1),
      .pixel (mask_px)
   );

   assign draw = in_box1 & mask_px & pos_valid & ~hblnk1 & ~vblnk1;

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         hcount_out <= '0;
         vcount_out <= '0;
         hsync_out  <= 1'b0;
         vsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         rgb_out    <= '0;
      end else begin
         hcount_out <= hcount1;
         vcount_out <= vcount1;
         hsync_out  <= hsync1;
         vsync_out  <= vsync1;
         hblnk_out  <= hblnk1;
         vblnk_out  <= vblnk1;
         rgb_out    <= draw ? BALL_COLOR : rgb1;
      end
   end
endmodule

// File: tb/tb_draw_ball.sv
// Self-checking bench for draw_ball: a behavioural model (ball position
// in effect = last position seen on a vblnk rising edge, circle test by
// plain integer arithmetic) predicts every output 2 cycles later, and a
// table plus hand-written spot checks pin down specific pixels.
module tb_draw_ball;
   logic        pclk = 1'b0;
   logic        rst;
   logic [10:0] hcount_in, vcount_in;
   logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
   logic [11:0] rgb_in;
   logic [11:0] xpos, ypos;
   logic [10:0] hcount_out, vcount_out;
   logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
   logic [11:0] rgb_out;

   draw_ball #(.BALL_DIAMETER(16), .BALL_COLOR(12'hFFF)) dut (
      .pclk       (pclk),
      .rst        (rst),
      .hcount_in  (hcount_in),
      .vcount_in  (vcount_in),
      .hsync_in   (hsync_in),
      .vsync_in   (vsync_in),
      .hblnk_in   (hblnk_in),
      .vblnk_in   (vblnk_in),
      .rgb_in     (rgb_in),
      .xpos       (xpos),
      .ypos       (ypos),
      .hcount_out (hcount_out),
      .vcount_out (vcount_out),
      .hsync_out  (hsync_out),
      .vsync_out  (vsync_out),
      .hblnk_out  (hblnk_out),
      .vblnk_out  (vblnk_out),
      .rgb_out    (rgb_out)
   );

   always #5 pclk = ~pclk;

   typedef struct packed {
      logic [10:0] hc;
      logic [10:0] vc;
      logic        hs;
      logic        vs;
      logic        hb;
      logic        vb;
      logic [11:0] rgb;
   } out_t;

   typedef struct {
      int unsigned h;
      int unsigned v;
      bit          hb;
      bit          ball;
   } vec_t;

   int    n_assert = 0;
   int    n_fail   = 0;
   string tname    = "init";

   // reference model state
   out_t  q[$];
   int    m_bx, m_by;
   bit    m_valid, m_prev;

   function automatic bit circle(int c, int r);
      int dc, dr;
      dc = 2 * c - 15;
      dr = 2 * r - 15;
      return (dc * dc + dr * dr) <= 256;
   endfunction

   function automatic out_t expect_out();
      out_t e;
      int   h, v;
      bit   ball;
      h = int'(hcount_in);
      v = int'(vcount_in);
      ball = m_valid && !hblnk_in && !vblnk_in &&
             h >= m_bx && h < m_bx + 16 && v >= m_by && v < m_by + 16 &&
             circle(h - m_bx, v - m_by);
      e.hc  = hcount_in;
      e.vc  = vcount_in;
      e.hs  = hsync_in;
      e.vs  = vsync_in;
      e.hb  = hblnk_in;
      e.vb  = vblnk_in;
      e.rgb = ball ? 12'hFFF : rgb_in;
      return e;
   endfunction

   task automatic cycle();
      out_t e, got;
      if (rst) begin
         @(posedge pclk); #1;
         e = '0;
         q.delete();
         q.push_back('0);
         m_valid = 1'b0; m_prev = 1'b0; m_bx = 0; m_by = 0;
      end else begin
         q.push_back(expect_out());
         if (vblnk_in && !m_prev) begin
            m_bx = int'(xpos); m_by = int'(ypos); m_valid = 1'b1;
         end
         m_prev = vblnk_in;
         @(posedge pclk); #1;
         e = q.pop_front();
      end
      got = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
      n_assert++;
      if (got !== e) begin
         n_fail++;
         $display("FAIL %s: got hc=%0d vc=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h, want hc=%0d vc=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h",
                  tname, got.hc, got.vc, got.hs, got.vs, got.hb, got.vb, got.rgb,
                  e.hc, e.vc, e.hs, e.vs, e.hb, e.vb, e.rgb);
      end
   endtask

   task automatic pix(int unsigned h, int unsigned v);
      hcount_in = 11'(h);
      vcount_in = 11'(v);
      hblnk_in  = (h >= 1024);
      vblnk_in  = (v >= 768);
      hsync_in  = 1'($urandom);
      vsync_in  = 1'($urandom);
      rgb_in    = 12'($urandom);
      cycle();
   endtask

   task automatic sweep(int unsigned h0, int unsigned h1, int unsigned v0, int unsigned v1);
      for (int unsigned v = v0; v <= v1; v++)
         for (int unsigned h = h0; h <= h1; h++)
            pix(h, v);
   endtask

   // position is captured on a single vblnk rising edge
   task automatic vrise(int unsigned x, int unsigned y);
      xpos = 12'(x);
      ypos = 12'(y);
      pix(5, 700);
      pix(0, 768);
      pix(0, 769);
      pix(6, 700);
   endtask

   task automatic spot(string nm, int unsigned h, int unsigned v, bit hb, bit ball);
      logic [11:0] want;
      hcount_in = 11'(h);
      vcount_in = 11'(v);
      hblnk_in  = hb;
      vblnk_in  = 1'b0;
      hsync_in  = 1'b0;
      vsync_in  = 1'b0;
      rgb_in    = 12'h5A5;
      cycle();
      pix(2000, 700);
      want = ball ? 12'hFFF : 12'h5A5;
      n_assert++;
      if (rgb_out !== want || hcount_out !== 11'(h)) begin
         n_fail++;
         $display("FAIL %s (%0d,%0d): got rgb=%h hc=%0d, want rgb=%h hc=%0d",
                  nm, h, v, rgb_out, hcount_out, want, h);
      end
   endtask

   vec_t latch_tbl[10];

   initial begin
      latch_tbl[0] = '{107, 200, 1'b0, 1'b1};
      latch_tbl[1] = '{100, 207, 1'b0, 1'b1};
      latch_tbl[2] = '{100, 200, 1'b0, 1'b0};
      latch_tbl[3] = '{116, 200, 1'b0, 1'b0};
      latch_tbl[4] = '{115, 207, 1'b0, 1'b1};
      latch_tbl[5] = '{108, 215, 1'b0, 1'b1};
      latch_tbl[6] = '{104, 200, 1'b0, 1'b0};
      latch_tbl[7] = '{99,  207, 1'b0, 1'b0};
      latch_tbl[8] = '{107, 216, 1'b0, 1'b0};
      latch_tbl[9] = '{107, 207, 1'b1, 1'b0};

      q.push_back('0);
      m_valid = 1'b0; m_prev = 1'b0; m_bx = 0; m_by = 0;
      rst = 1'b1;
      hcount_in = '0; vcount_in = '0; hsync_in = 1'b0; vsync_in = 1'b0;
      hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = '0; xpos = '0; ypos = '0;

      tname = "reset";
      for (int i = 0; i < 3; i++) begin
         rgb_in = 12'($urandom);
         cycle();
      end
      rst = 1'b0;

      tname = "first_frame";
      xpos = 12'd100; ypos = 12'd200;
      sweep(98, 118, 198, 216);

      tname = "latch";
      vrise(100, 200);
      for (int i = 0; i < 10; i++)
         spot("latch_tbl", latch_tbl[i].h, latch_tbl[i].v, latch_tbl[i].hb, latch_tbl[i].ball);
      sweep(96, 119, 198, 217);

      tname = "tear";
      xpos = 12'd300;
      spot("tear_old", 107, 200, 1'b0, 1'b1);
      sweep(96, 119, 200, 215);
      spot("tear_new_absent", 307, 200, 1'b0, 1'b0);
      vrise(300, 200);
      spot("tear_moved", 307, 200, 1'b0, 1'b1);
      spot("tear_old_gone", 107, 200, 1'b0, 1'b0);
      sweep(296, 319, 200, 215);

      tname = "edge_clip";
      vrise(1018, 760);
      sweep(1012, 1023, 758, 767);
      sweep(0, 5, 760, 767);
      sweep(1018, 1023, 0, 3);
      spot("clip_corner", 1023, 767, 1'b0, 1'b1);
      spot("clip_top", 1023, 760, 1'b0, 1'b1);
      spot("clip_rowtop_c2", 1020, 760, 1'b0, 1'b0);
      spot("clip_nowrap_h", 0, 767, 1'b0, 1'b0);
      spot("clip_nowrap_v", 1023, 0, 1'b0, 1'b0);

      tname = "far_pos";
      vrise(2048, 0);
      sweep(0, 20, 0, 3);
      spot("far_wrap", 7, 0, 1'b0, 1'b0);
      spot("far_max", 2047, 7, 1'b0, 1'b0);

      tname = "reset_mid";
      vrise(40, 290);
      sweep(38, 58, 295, 299);
      pix(45, 300);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) pix(46 + i, 300);
      rst = 1'b0;
      sweep(38, 58, 300, 306);
      spot("reset_noball", 47, 300, 1'b0, 1'b0);
      vrise(40, 290);
      spot("reset_back", 47, 300, 1'b0, 1'b1);

      tname = "blank";
      vrise(1020, 100);
      sweep(1016, 1040, 100, 115);
      spot("blank_hb", 1024, 107, 1'b1, 1'b0);
      spot("blank_vis", 1023, 107, 1'b0, 1'b1);

      tname = "random";
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            xpos = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(2048, 4095))
                                               : 12'($urandom_range(0, 48));
            ypos = 12'($urandom_range(0, 48));
         end
         if ($urandom_range(0, 499) == 0) rst = 1'b1;
         else rst = 1'b0;
         hcount_in = 11'($urandom_range(0, 63));
         vcount_in = 11'($urandom_range(0, 63));
         hsync_in  = 1'($urandom);
         vsync_in  = 1'($urandom);
         hblnk_in  = ($urandom_range(0, 7) == 0);
         vblnk_in  = ($urandom_range(0, 7) == 0);
         rgb_in    = 12'($urandom);
         cycle();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/draw_ball.md
DRAW_BALL -- requirements
Module: draw_ball

Interface
REQ-001 Parameter BALL_DIAMETER, default 16, SHALL set the sprite edge length in pixels; only the value 16 is supported.
REQ-002 Parameter BALL_COLOR, default 12'hF_F_F, SHALL set the RGB444 colour of ball pixels.
REQ-003 pclk  in  1  pixel clock; the only clock.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 hcount_in, vcount_in  in  11 each  pixel coordinates from the upstream VGA stage.
REQ-006 hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  upstream sync and blanking.
REQ-007 rgb_in  in  12  upstream pixel colour.
REQ-008 xpos, ypos  in  12 each  ball top-left position from draw_ball_ctl.
REQ-009 hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out  out  same widths as inputs  delayed timing and overlaid colour.

Function
REQ-010 Every output SHALL equal its corresponding input delayed by exactly 2 pclk cycles (fixed latency), with rgb_out modified only as REQ-014 requires.
REQ-011 The block SHALL register vblnk_in and detect its rising edge (vblnk_in=1, previous=0).
REQ-012 On that rising edge, it SHALL latch xpos/ypos into bx/by and set pos_valid=1; bx/by SHALL NOT change at any other time, so no frame tears.
REQ-013 Stage 1 SHALL compute dx=hcount_in-bx and dy=vcount_in-by in 12-bit unsigned arithmetic, plus in_box = (hcount_in>=bx) && (dx<16) && (vcount_in>=by) && (dy<16); operands are zero-extended to 12 bits.
REQ-014 Stage 2 SHALL output rgb_out=BALL_COLOR when in_box && mask(dy[3:0],dx[3:0]) && pos_valid && !hblnk && !vblnk at that pixel; otherwise rgb_out SHALL be the delayed rgb_in.
REQ-015 mask SHALL be a 16x16 circle: bit(r,c)=1 iff (2c-15)^2+(2r-15)^2 <= 256. Rows 0 and 15 SHALL have columns 5..10 set.
REQ-016 Boundary: a box extending past hcount 1023 or vcount 767 SHALL be drawn only where the coordinates exist; no wrap to column 0 or row 0.
REQ-017 Boundary: xpos or ypos >= 2048 SHALL produce no ball pixels, because in_box is always false.
REQ-018 Simultaneous events: if xpos/ypos change in the same cycle as the vblnk rising edge, the values present in that cycle SHALL be latched.
REQ-019 The first frame after reset, before any vblnk rising edge, SHALL contain no ball pixels (pos_valid=0).

Reset
REQ-020 While rst=1, all outputs, both pipeline stages, bx, by, the vblnk delay register and pos_valid SHALL be 0.
REQ-021 Assertion of rst mid-frame SHALL clear state immediately; after deassertion, the outputs SHALL carry valid delayed data 2 cycles later, and no ball SHALL be drawn until the next vblnk rising edge.

Structure
REQ-022 A shared package (vga_pkg) SHALL hold BALL_DIAMETER, the screen constants (1024x768, CENTRAL_LINE=511) and the RGB width.
REQ-023 The package contents SHALL be the same constants that draw_ball_ctl uses.
REQ-024 The mask SHALL be a sub-module ball_rom: combinational, 4-bit row and 4-bit column in, 1-bit pixel out, read in stage 2 using registered dy/dx.
REQ-025 All other logic SHALL be in draw_ball: two register stages, the latch and the edge detector.

Verification
REQ-026 Latch test: xpos=100, ypos=200, one full frame -> next frame has rgb_out=FFF at (107,200) and (100,207), is unchanged at (100,200) (corner) and (116,200), with latency 2 cycles vs hcount_out.
REQ-027 Tear test: change xpos 100->300 mid-frame at vcount 400 -> rows 200..215 of the current frame still show the ball at 100; the next frame shows it at 300.
REQ-028 Edge clip: xpos=1018, ypos=760 -> ball pixels only at hcount<=1023 and vcount<=767; none at hcount 0..5 or vcount 0..3.
REQ-029 Reset test: assert rst at vcount 300 for 5 cycles -> all outputs 0 during reset, rgb_out=rgb_in delayed with no ball for the remainder of the frame, ball reappears the frame after the next vblnk.
REQ-030 Blanking test: xpos=1020 with hblnk_in=1 over hcount 1024.. -> rgb_out equals delayed rgb_in at every blanked pixel.
REQ-031 Timing passthrough: random stream -> hsync/vsync/hblnk/vblnk/hcount/vcount outputs match inputs delayed 2 cycles, bit-exact, over 2 frames.
